// File: rtl/e_mdu_pkg.sv
// mdu_defs: shared HILO operation codes and default multiply/divide timing.
// Used by the E-stage MDU, the main decoder and the hazard unit.
package mdu_defs;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } hilo_op_t;
endpackage

// File: rtl/e_mdu_calc.sv
// mdu_calc: combinational multiply/divide datapath producing the HI/LO result.
// Ports: op (HILO op code), a/b (operands), hi/lo (current registers),
//        temp_hi/temp_lo (result; current hi/lo for non-MD ops or divide by zero).
module mdu_calc
    import mdu_defs::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] temp_hi,
    output logic [WIDTH-1:0] temp_lo
);
    logic [2*WIDTH-1:0] sprod, uprod, res;
    logic neg_a, neg_b;
    logic [WIDTH-1:0] dvd, dvs, q, r, sq, sr;
    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // One unsigned divider on magnitudes serves both DIV and DIVU; signs are
    // reapplied afterwards, so MIN/-1 wraps to MIN with remainder 0.
    assign neg_a = (op == OP_DIV) && a[WIDTH-1];
    assign neg_b = (op == OP_DIV) && b[WIDTH-1];
    assign dvd = neg_a ? -a : a;
    assign dvs = neg_b ? -b : b;
    assign q = dvd / dvs;
    assign r = dvd % dvs;
    assign sq = (neg_a ^ neg_b) ? -q : q;
    assign sr = neg_a ? -r : r;
    always_comb begin
        res = {hi, lo};
        res = (op == OP_MULT) ? sprod :
              (op == OP_MULTU) ? uprod :
              ((op == OP_DIV || op == OP_DIVU) && b != '0) ? {sr, sq} : {hi, lo};
    end
    assign temp_hi = res[2*WIDTH-1:WIDTH];
    assign temp_lo = res[WIDTH-1:0];
endmodule

// File: rtl/e_mdu.sv
// e_mdu: E-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (async active-low), start/hilo_op/rs_val/rt_val (from ID/EX),
//        busy (op in flight), hi/lo (architectural regs), hilo_rdata (MFHI/MFLO read).
module e_mdu
    import mdu_defs::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       hilo_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_rdata
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] temp_hi, temp_lo, calc_hi, calc_lo;
    logic is_mult, is_div;
    assign is_mult = hilo_op == OP_MULT || hilo_op == OP_MULTU;
    assign is_div = hilo_op == OP_DIV || hilo_op == OP_DIVU;
    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op(hilo_op),
        .a(rs_val),
        .b(rt_val),
        .hi(hi),
        .lo(lo),
        .temp_hi(calc_hi),
        .temp_lo(calc_lo)
    );
    // cnt == 0 is IDLE; a nonzero count is RUN and reaches the commit at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            busy <= 1'b0;
            hi <= '0;
            lo <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                hi <= temp_hi;
                lo <= temp_lo;
                busy <= 1'b0;
            end
        end else if (start && (is_mult || is_div)) begin
            temp_hi <= calc_hi;
            temp_lo <= calc_lo;
            cnt <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy <= 1'b1;
        end else if (hilo_op == OP_MTHI) begin
            hi <= rs_val;
        end else if (hilo_op == OP_MTLO) begin
            lo <= rs_val;
        end
    end
    assign hilo_rdata = (hilo_op == OP_MFHI) ? hi : (hilo_op == OP_MFLO) ? lo : '0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu with a cycle-scheduled arithmetic model.
module tb_e_mdu;
    import mdu_defs::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [3:0] hilo_op = 4'd0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic busy;
    logic [31:0] hi, lo, hilo_rdata;
    int checks = 0, failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    logic m_pending = 1'b0;
    longint m_cyc = 0, m_done_at = 0;

    e_mdu dut (
        .clk(clk), .reset(reset), .start(start), .hilo_op(hilo_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo),
        .hilo_rdata(hilo_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a, b, h, l);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 4'd1) return 64'(sa * sb);
        if (op == 4'd2) return ua * ub;
        if (b == 32'd0) return {h, l};
        if (op == 4'd3) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: schedule each MD result to land N edges after launch.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_hi = '0;
            m_lo = '0;
            m_pending = 1'b0;
        end else begin
            m_cyc++;
            if (m_pending) begin
                if (start && hilo_op inside {[4'd1:4'd4]}) begin
                    checks++;
                    failures++;
                    $display("FAIL start_while_busy: got start=1 expected start=0 at %0t", $time);
                end
                if (m_cyc == m_done_at) begin
                    {m_hi, m_lo} = m_res;
                    m_pending = 1'b0;
                end
            end else if (start && hilo_op inside {[4'd1:4'd4]}) begin
                m_res = model_res(hilo_op, rs_val, rt_val, m_hi, m_lo);
                m_done_at = m_cyc + ((hilo_op <= 4'd2) ? 5 : 10);
                m_pending = 1'b1;
            end else if (hilo_op == 4'd7) begin
                m_hi = rs_val;
            end else if (hilo_op == 4'd8) begin
                m_lo = rs_val;
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", {31'd0, busy}, {31'd0, m_pending});
        check("model_hi", hi, m_hi);
        check("model_lo", lo, m_lo);
        check("model_rdata", hilo_rdata, hilo_op == 4'd5 ? m_hi : hilo_op == 4'd6 ? m_lo : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, b);
        start = s;
        hilo_op = op;
        rs_val = a;
        rt_val = b;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, b,
                          input int n, input logic [31:0] eh, el);
        drive(1'b1, op, a, b);
        tick();
        drive(1'b0, 4'd0, '0, '0);
        for (int i = 1; i <= n; i++) begin
            check({name, "_busy"}, {31'd0, busy}, 32'd1);
            tick();
        end
        check({name, "_done"}, {31'd0, busy}, 32'd0);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    initial begin
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        tick();
        run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        drive(1'b0, OP_MTHI, 32'h12345678, '0);
        tick();
        drive(1'b0, OP_MFLO, '0, '0);
        #1 check("mflo", hilo_rdata, 32'h80000000);
        drive(1'b0, OP_MFHI, '0, '0);
        #1 check("mfhi", hilo_rdata, 32'h12345678);
        drive(1'b0, OP_NONE, '0, '0);
        #1 check("rdata_none", hilo_rdata, 32'd0);
        drive(1'b1, OP_MULTU, 32'd3, 32'd4);
        tick();
        drive(1'b0, OP_MTLO, 32'hDEADBEEF, '0);
        tick();
        drive(1'b0, OP_NONE, '0, '0);
        check("mtlo_busy_lo", lo, 32'h80000000);
        repeat (4) tick();
        check("multu34_hi", hi, 32'd0);
        check("multu34_lo", lo, 32'd12);
        drive(1'b0, OP_MTLO, 32'hCAFEF00D, '0);
        tick();
        drive(1'b0, OP_MTHI, 32'h0BADF00D, '0);
        tick();
        check("mtlo_idle", lo, 32'hCAFEF00D);
        check("mthi_idle", hi, 32'h0BADF00D);
        drive(1'b1, OP_DIV, 32'd100, 32'd3);
        tick();
        drive(1'b0, OP_NONE, '0, '0);
        repeat (3) tick();
        #1 reset = 1'b0;
        #1;
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_hi", hi, 32'd0);
        check("async_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_op("mult34", OP_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);
        run_op("b2b_mult", OP_MULT, 32'hFFFFFFFB, 32'd6, 5, 32'hFFFFFFFF, 32'hFFFFFFE2);
        run_op("b2b_div", OP_DIV, 32'hFFFFFF9C, 32'd7, 10, 32'hFFFFFFFE, 32'hFFFFFFF2);
        run_op("div_pos_neg", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
